systolic_feeder: RTL and testbench

- Edge feeder for the systolic matrix-multiply array.
- Accepts one k-slice per handshake: column k of A (N elements) and row k of B (N elements).
- Drives the array's west (row) and north (column) operand edges with diagonal skew: lane i is delayed i cycles, with a per-lane load strobe.
- Runs one job of cfg_k slices per start, then flushes the skew pipeline and pulses done.

---
 rtl/systolic_feeder.sv | 159 +++++++++++++++
 tb/tb_systolic_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Edge feeder for a systolic matrix-multiply array: diagonal skew of A columns / B rows.
// Optional `define SYSTOLIC_FEEDER_ZERO_GATE_EN zeroes data lanes whose load strobe is low.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int KW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   cfg_k,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_slice,
    input  logic [N*DW-1:0] b_slice,
    output logic [N*DW-1:0] row_data,
    output logic [N-1:0]    row_load,
    output logic [N*DW-1:0] col_data,
    output logic [N-1:0]    col_load,
    output logic            busy,
    output logic            done
);

    localparam int FW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [KW-1:0]   r_cfg_k;
    logic [KW-1:0]   r_k_cnt;
    logic [FW-1:0]   r_fl_cnt;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last_slice;
    logic            w_last_flush;
    logic [N*DW-1:0] w_a_in;
    logic [N*DW-1:0] w_b_in;

    assign w_accept     = in_valid && r_in_ready;
    assign w_last_slice = (r_k_cnt == (r_cfg_k - {{(KW-1){1'b0}}, 1'b1}));
    assign w_last_flush = (r_fl_cnt == FW'(N - 1));

`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    // Gating at chain entry is enough: a zeroed word travels alongside its load=0 bit.
    assign w_a_in = w_accept ? a_slice : {(N*DW){1'b0}};
    assign w_b_in = w_accept ? b_slice : {(N*DW){1'b0}};
`else
    assign w_a_in = a_slice;
    assign w_b_in = b_slice;
`endif

    // Next-state decode for the job sequencer.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_k == {KW{1'b0}}) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_FEED;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_FEED: begin
                if (w_accept && w_last_slice) begin
                    w_state_nx = S_FLUSH;
                end else begin
                    w_state_nx = S_FEED;
                end
            end
            S_FLUSH: begin
                if (w_last_flush) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_FLUSH;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State, counters and registered status outputs (decoded from next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cfg_k    <= {KW{1'b0}};
            r_k_cnt    <= {KW{1'b0}};
            r_fl_cnt   <= {FW{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx == S_FEED);
            r_busy     <= (w_state_nx == S_FEED) || (w_state_nx == S_FLUSH);
            r_done     <= (w_state_nx == S_DONE);
            if ((r_state == S_IDLE) && start) begin
                r_cfg_k <= cfg_k;
                r_k_cnt <= {KW{1'b0}};
            end else if (w_accept) begin
                r_k_cnt <= r_k_cnt + {{(KW-1){1'b0}}, 1'b1};
            end else begin
                r_k_cnt <= r_k_cnt;
            end
            if ((r_state == S_FLUSH) && !w_last_flush) begin
                r_fl_cnt <= r_fl_cnt + {{(FW-1){1'b0}}, 1'b1};
            end else begin
                r_fl_cnt <= {FW{1'b0}};
            end
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

    // Lane i holds i+1 registers; the last one is the output register, giving latency i+1.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [i:0]    r_ld;
        logic [DW-1:0] r_a [0:i];
        logic [DW-1:0] r_b [0:i];

        // Skew shift chain carrying {load, A, B} for this lane.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ld <= '0;
                for (int s = 0; s <= i; s++) begin
                    r_a[s] <= {DW{1'b0}};
                    r_b[s] <= {DW{1'b0}};
                end
            end else begin
                r_ld[0] <= w_accept;
                r_a[0]  <= w_a_in[i*DW +: DW];
                r_b[0]  <= w_b_in[i*DW +: DW];
                for (int s = 1; s <= i; s++) begin
                    r_ld[s] <= r_ld[s-1];
                    r_a[s]  <= r_a[s-1];
                    r_b[s]  <= r_b[s-1];
                end
            end
        end

        assign row_load[i]           = r_ld[i];
        assign col_load[i]           = r_ld[i];
        assign row_data[i*DW +: DW]  = r_a[i];
        assign col_data[i*DW +: DW]  = r_b[i];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4); expected skew patterns derived per lane.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   cfg_k;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_slice;
    logic [N*DW-1:0] b_slice;
    logic [N*DW-1:0] row_data;
    logic [N-1:0]    row_load;
    logic [N*DW-1:0] col_data;
    logic [N-1:0]    col_load;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_feeder #(.N(N), .DW(DW), .KW(KW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_k    (cfg_k),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_slice  (a_slice),
        .b_slice  (b_slice),
        .row_data (row_data),
        .row_load (row_load),
        .col_data (col_data),
        .col_load (col_load),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slice k, lane i: A = 256k+i+1, B = 256k+i+5 (slice 0 gives A {4,3,2,1}, B {8,7,6,5}).
    function automatic logic [N*DW-1:0] a_vec(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(256*k + i + 1);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] b_vec(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(256*k + i + 5);
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row_load"}, 64'(row_load), 64'd0);
        chk({tag, "_col_load"}, 64'(col_load), 64'd0);
        chk({tag, "_row_data"}, 64'(row_data != '0), 64'd0);
        chk({tag, "_col_data"}, 64'(col_data != '0), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Runs one job; vpat[c] is in_valid in the c-th FEED-side cycle. A stray start is
    // injected mid-job and must be ignored. Intervals are counted from the first FEED cycle.
    task automatic run_job(input string nm, input int kk, input logic [15:0] vpat,
                           input int plen, input int exp_busy, input int exp_done);
        int   nv, busy_n, done_n, done_at, p, kidx;
        logic ld_exp;
        cfg_k = KW'(kk);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_ready_first"}, 64'(in_ready), 64'd1);
        busy_n  = busy ? 1 : 0;
        done_n  = 0;
        done_at = -1;
        nv      = 0;
        for (int c = 0; c <= plen + N + 1; c++) begin
            in_valid = (c < plen) ? vpat[c] : 1'b0;
            a_slice  = a_vec(nv);
            b_slice  = b_vec(nv);
            if (c == 1) begin
                start = 1'b1;
                cfg_k = KW'(0);
            end else begin
                start = 1'b0;
            end
            tick();
            if (in_valid) nv++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = c + 1;
            end
            for (int i = 0; i < N; i++) begin
                p      = c - i;
                ld_exp = (p >= 0 && p < plen) ? vpat[p] : 1'b0;
                kidx   = 0;
                for (int q = 0; q < p && q < plen; q++) if (vpat[q]) kidx++;
                chk($sformatf("%s_row_load_c%0d_l%0d", nm, c, i), 64'(row_load[i]), 64'(ld_exp));
                chk($sformatf("%s_col_load_c%0d_l%0d", nm, c, i), 64'(col_load[i]), 64'(ld_exp));
                if (ld_exp) begin
                    chk($sformatf("%s_row_data_c%0d_l%0d", nm, c, i),
                        64'(row_data[i*DW +: DW]), 64'(256*kidx + i + 1));
                    chk($sformatf("%s_col_data_c%0d_l%0d", nm, c, i),
                        64'(col_data[i*DW +: DW]), 64'(256*kidx + i + 5));
                end else begin
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
                    chk($sformatf("%s_row_gate_c%0d_l%0d", nm, c, i), 64'(row_data[i*DW +: DW]), 64'd0);
                    chk($sformatf("%s_col_gate_c%0d_l%0d", nm, c, i), 64'(col_data[i*DW +: DW]), 64'd0);
`endif
                end
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk({nm, "_busy_span"}, 64'(busy_n),  64'(exp_busy));
        chk({nm, "_done_at"},   64'(done_at), 64'(exp_done));
        chk({nm, "_done_cnt"},  64'(done_n),  64'd1);
        tick();
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        start    = 1'b0;
        cfg_k    = '0;
        in_valid = 1'b0;
        a_slice  = '0;
        b_slice  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Abort a cfg_k=3 job in its second FLUSH cycle with an asynchronous reset.
        cfg_k = KW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a_slice  = a_vec(c);
            b_slice  = b_vec(c);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("abort_pre_load", 64'(row_load != '0), 64'd1);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1 chk_all_zero("abort");
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || busy || in_ready || row_load != '0) bad++;
        end
        chk("abort_quiet", 64'(bad), 64'd0);

        // cfg_k=1: lane i strobes at t+1+i, done at t+5.
        run_job("k1", 1, 16'b1, 1, 5, 5);
        // cfg_k=4 back to back: busy spans 8 cycles, done at t+8.
        run_job("k4", 4, 16'b1111, 4, 8, 8);
        // cfg_k=3 with a two-cycle bubble: pattern 1,0,0,1,1 per lane.
        run_job("k3b", 3, 16'b11001, 5, 9, 9);

        // cfg_k=0: straight to DONE, no strobes, in_ready never set.
        cfg_k = KW'(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("k0_done",     64'(done),     64'd1);
        chk("k0_busy",     64'(busy),     64'd0);
        chk("k0_in_ready", 64'(in_ready), 64'd0);
        chk("k0_row_load", 64'(row_load), 64'd0);
        tick();
        chk("k0_done_end", 64'(done),     64'd0);
        chk("k0_idle_rdy", 64'(in_ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
